// File: rtl/serial_adder_fsm_pkg.sv
// Shared types for the bit-serial adder: FSM state encoding.
package serial_adder_fsm_pkg;

    // Controller states; encodings are fixed so checkers can decode them.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_adder_fsm_fa.sv
// One-bit full-adder cell (dataflow form) driven by the serial adder.
module fa_dataflow (
    output logic s,
    output logic co,
    input  logic a,
    input  logic b,
    input  logic ci
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder_fsm.sv
// Bit-serial N-bit adder: one full-adder cell, one bit per clock, LSB first.
// Handshake: start is honoured only in IDLE; busy is high for the N SHIFT
// cycles; done pulses for one cycle and sum/co are valid from that cycle
// until the next completed operation. Requests while busy or done are dropped.
module serial_adder_fsm
    import serial_adder_fsm_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a_in,
    input  logic [N-1:0] b_in,
    input  logic         ci_in,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] sum,
    output logic         co
);

    localparam int CW = $clog2(N);

    state_t        r_state;
    state_t        w_next_state;
    logic [N-1:0]  r_a_sh;
    logic [N-1:0]  r_b_sh;
    logic [N-1:0]  r_sum_sh;
    logic [N-1:0]  r_sum;
    logic          r_c;
    logic          r_co;
    logic [CW-1:0] r_cnt;
    logic          w_s;
    logic          w_co;
    logic          w_last;

    // The single cell sees the current LSBs and the carry flip-flop.
    fa_dataflow u_fa (
        .s  (w_s),
        .co (w_co),
        .a  (r_a_sh[0]),
        .b  (r_b_sh[0]),
        .ci (r_c)
    );

    assign w_last = (r_cnt == CW'(N - 1));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: IDLE -> SHIFT on start, SHIFT -> DONE after N bits,
    // DONE -> IDLE unconditionally.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next_state = S_SHIFT;
            S_SHIFT: if (w_last) w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Datapath: operand capture, shifting, carry feedback and result load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_sum_sh <= '0;
            r_sum    <= '0;
            r_c      <= 1'b0;
            r_co     <= 1'b0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a_sh <= a_in;
                        r_b_sh <= b_in;
                        r_c    <= ci_in;
                        r_cnt  <= '0;
                    end
                end
                S_SHIFT: begin
                    r_sum_sh <= {w_s, r_sum_sh[N-1:1]};
                    r_a_sh   <= r_a_sh >> 1;
                    r_b_sh   <= r_b_sh >> 1;
                    r_c      <= w_co;
                    if (w_last) begin
                        // Final bit: publish the result; counter holds so it never wraps.
                        r_sum <= {w_s, r_sum_sh[N-1:1]};
                        r_co  <= w_co;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy = (r_state == S_SHIFT);
    assign done = (r_state == S_DONE);
    assign sum  = r_sum;
    assign co   = r_co;

endmodule

// File: tb/tb_serial_adder_fsm.sv
// Directed and randomized bench for serial_adder_fsm (N=4) against an
// arithmetic reference: {co,sum} = a + b + ci.
module tb_serial_adder_fsm;

    localparam int N = 4;

    logic         clk;
    logic         rst;
    logic         start;
    logic [N-1:0] a_in;
    logic [N-1:0] b_in;
    logic         ci_in;
    logic         busy;
    logic         done;
    logic [N-1:0] sum;
    logic         co;

    int n_pass;
    int n_total;
    int n_fail;
    logic [N:0] exp_q[$];

    serial_adder_fsm #(.N(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a_in  (a_in),
        .b_in  (b_in),
        .ci_in (ci_in),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .co    (co)
    );

    // Clock generation.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [N:0] model(input logic [N-1:0] a, input logic [N-1:0] b, input logic ci);
        int e;
        e = int'(a) + int'(b) + int'(ci);
        return e[N:0];
    endfunction

    // One full transaction from IDLE; 'full' adds timing and hold checks.
    task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic ci, input bit full);
        int lat;
        int bcnt;
        logic [N:0] e;
        exp_q.push_back(model(a, b, ci));
        a_in = a; b_in = b; ci_in = ci; start = 1'b1;
        tick();
        start = 1'b0;
        lat = 0; bcnt = 0;
        while (done !== 1'b1 && lat < 4 * N) begin
            if (busy === 1'b1) bcnt++;
            tick();
            lat++;
        end
        e = exp_q.pop_front();
        check("result", {co, sum}, e);
        if (full) begin
            check("latency", lat, N);
            check("busy_cycles", bcnt, N);
        end
        tick();
        if (full) begin
            check("done_single", done, 1'b0);
            check("hold_result", {co, sum}, e);
        end
    endtask

    initial begin
        int ndone;
        int fail_before;
        logic [N:0] res;
        logic [N:0] e;
        n_pass = 0; n_total = 0; n_fail = 0;
        rst = 1'b0; start = 1'b0; a_in = '0; b_in = '0; ci_in = 1'b0;

        // Reset state.
        #2 rst = 1'b1;
        #2;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_result", {co, sum}, 0);
        tick(); tick();
        rst = 1'b0;
        tick();

        // Basic sum and carry ripple cases.
        do_op(4'b0011, 4'b0101, 1'b0, 1'b1);
        do_op(4'b1111, 4'b0001, 1'b0, 1'b1);
        do_op(4'b1111, 4'b1111, 1'b1, 1'b1);

        // start during SHIFT is ignored.
        a_in = 4'b0001; b_in = 4'b0001; ci_in = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        a_in = 4'b1111; start = 1'b1;
        tick();
        start = 1'b0; a_in = '0;
        ndone = 0; res = '0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done === 1'b1) begin
                ndone++;
                res = {co, sum};
            end
        end
        check("ignore_start_dones", ndone, 1);
        check("ignore_start_result", res, model(4'b0001, 4'b0001, 1'b0));

        // Async reset mid-SHIFT, after a nonzero result is held.
        do_op(4'b1001, 4'b0100, 1'b0, 1'b0);
        a_in = 4'b0101; b_in = 4'b0111; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        #2 rst = 1'b1;
        #1;
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_result", {co, sum}, 0);
        tick(); tick();
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done === 1'b1) ndone++;
        end
        check("abort_no_done", ndone, 0);
        do_op(4'b0110, 4'b0011, 1'b0, 1'b1);

        // start held high: accepts every N+2 cycles.
        a_in = 4'($urandom_range(0, 15)); b_in = 4'($urandom_range(0, 15));
        ci_in = 1'($urandom_range(0, 1)); start = 1'b1;
        for (int c = 0; c < 36; c++) begin
            tick();
            if (c % (N + 2) == 0) begin
                exp_q.push_back(model(a_in, b_in, ci_in));
                a_in = 4'($urandom_range(0, 15)); b_in = 4'($urandom_range(0, 15));
                ci_in = 1'($urandom_range(0, 1));
            end
            check("b2b_done", done, (c % (N + 2) == N) ? 1'b1 : 1'b0);
            if (c % (N + 2) == N && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("b2b_result", {co, sum}, e);
            end
        end
        start = 1'b0;
        tick(); tick();
        exp_q.delete();

        // Random operations.
        for (int i = 0; i < 16; i++) begin
            do_op(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'b1);
        end

        // Exhaustive sweep of {ci,a,b}.
        fail_before = n_fail;
        for (int ci = 0; ci < 2; ci++) begin
            for (int a = 0; a < 16; a++) begin
                for (int b = 0; b < 16; b++) begin
                    do_op(4'(a), 4'(b), 1'(ci), 1'b0);
                end
            end
        end
        $display("exhaustive sweep: %0d mismatches", n_fail - fail_before);
        check("exhaustive_mismatches", n_fail - fail_before, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
